expr_eval: RTL and testbench
============================

Name: expr_eval

Overview:
- Downstream consumer of the ASCII character stream that the expression-string recogniser checks.
- Accepts one ASCII byte per valid cycle and evaluates an integer infix expression terminated by '='.
- Emits a one-cycle result strobe carrying the value, or an error flag for malformed input.
- Operators: '+', '-', '*'. '*' has precedence over '+'/'-'. Operands are multi-digit decimal.

Parameters:
W, 16, result and accumulator width; all arithmetic is two's complement modulo 2^W.

Ports:
clk  input  1  system clock, rising edge
clr  input  1  reset, asynchronous, active-low
in_valid  input  1  in carries a character this cycle
in  input  8  ASCII character
res_valid  output  1  one-cycle pulse: result/err valid
result  output  W  expression value (0 when err=1)
err  output  1  malformed expression flag, qualified by res_valid
busy  output  1  high while an expression is partially received

Behaviour:
- Reset (clr=0, asynchronous) forces the following, and reset has priority over any in_valid:
  - state=IDLE
  - sum=0, term=0, num=0, mul_pend=0, neg_pend=0
  - res_valid=0, result=0, err=0, busy=0
- in_valid=0 leaves all state unchanged; res_valid still drops after its pulse.
- Character classes: digit '0'..'9'; op '+' '-' '*'; '=' terminator; ' ' ignored in every state; anything else is invalid.
- States:
  - IDLE: expects the first digit.
  - NUM: inside a number.
  - OPR: an operator was just accepted; expects a digit.
  - ERR: discarding input until '='.
- Digit in IDLE/NUM/OPR: num <= num*10 + d (mod 2^W); go to NUM.
- Operator in NUM. First compute t = mul_pend ? term*num : num, then:
  - '*': term<=t, mul_pend<=1.
  - '+'/'-': sum <= sum + (neg_pend ? -t : t); neg_pend <= (op=='-'); mul_pend<=0.
  - In all operator cases num<=0 and the state goes to OPR.
- '=' in NUM:
  - result <= sum + (neg_pend ? -t : t), err<=0, res_valid<=1.
  - All accumulators clear; go to IDLE.
- Error entry goes to ERR: an operator in IDLE or OPR, or an invalid character in IDLE/NUM/OPR.
- In ERR, every character except '=' is ignored.
- '=' in IDLE, OPR or ERR: result<=0, err<=1, res_valid<=1, accumulators clear, go to IDLE.
- Latency: res_valid rises on the same clock edge that samples '='; it is high for exactly one cycle. result and err hold their values until the next strobe.
- A new expression may start on the cycle immediately after '=' (back-to-back supported; no stall, no ready signal).
- busy=1 in NUM, OPR and ERR; busy=0 in IDLE.
- Overflow wraps silently and raises no error. Leading zeros are accepted.
- Unary minus is not supported: a leading '-' is an error.

Test Plan:
1. Reset, then "1","+","1","=" on consecutive cycles -> res_valid pulses for 1 cycle on the '=' edge; result=2, err=0, busy back to 0.
2. "12+3*4=" -> result=24. Then immediately "2*3-10=" back-to-back -> result=16'hFFFC (-4), err=0.
3. "1++2=" -> res_valid with err=1, result=0. Next "7=" -> result=7, err=0 (error state fully cleared).
4. Stream "3", in_valid low for 3 cycles, " ", "*", "5", "=" -> result=15. Also check "300*300=" with W=16 -> result=24464 (90000 mod 65536).
5. Bad endings: "=" alone, "4*=", and "4#2=" -> each gives err=1, result=0, exactly one res_valid pulse per '='.
6. Send "9+", pull clr low mid-cycle (asynchronous) for 2 cycles, release, then send "4=" -> busy drops during reset; the next result is 4 with no residue from 9.

Source files
------------

// File: rtl/expr_eval.sv
// Streaming evaluator for ASCII infix integer expressions ('+', '-', '*', '=').
// '*' binds tighter than '+'/'-'; all arithmetic wraps modulo 2^W.
module expr_eval #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic         res_valid,
  output logic [W-1:0] result,
  output logic         err,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NUM  = 2'd1,
    OPR  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] TEN  = W'(4'd10);

  state_t       state_r;
  logic [W-1:0] sum_r;
  logic [W-1:0] term_r;
  logic [W-1:0] num_r;
  logic         mul_pend_r;
  logic         neg_pend_r;

  logic         is_digit_s;
  logic         is_op_s;
  logic         is_eq_s;
  logic         is_space_s;
  logic [W-1:0] digit_s;
  logic [W-1:0] t_s;
  logic [W-1:0] signed_t_s;
  logic [W-1:0] total_s;
  logic [W-1:0] num_next_s;

  // Character decode and the arithmetic shared by operator and '=' handling.
  always_comb begin
    is_digit_s = (in >= 8'h30) && (in <= 8'h39);
    is_op_s    = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A);
    is_eq_s    = (in == 8'h3D);
    is_space_s = (in == 8'h20);
    // ASCII '0'..'9' carry the digit value in their low nibble
    digit_s    = {{(W-4){1'b0}}, in[3:0]};
    if (mul_pend_r) begin
      t_s = term_r * num_r;
    end else begin
      t_s = num_r;
    end
    if (neg_pend_r) begin
      signed_t_s = ZERO - t_s;
    end else begin
      signed_t_s = t_s;
    end
    total_s    = sum_r + signed_t_s;
    num_next_s = (num_r * TEN) + digit_s;
  end

  // Parser FSM, accumulators and registered result outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r    <= IDLE;
      sum_r      <= '0;
      term_r     <= '0;
      num_r      <= '0;
      mul_pend_r <= 1'b0;
      neg_pend_r <= 1'b0;
      res_valid  <= 1'b0;
      result     <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (in_valid && !is_space_s) begin
        if (is_eq_s) begin
          res_valid <= 1'b1;
          if (state_r == NUM) begin
            result <= total_s;
            err    <= 1'b0;
          end else begin
            result <= '0;
            err    <= 1'b1;
          end
          sum_r      <= '0;
          term_r     <= '0;
          num_r      <= '0;
          mul_pend_r <= 1'b0;
          neg_pend_r <= 1'b0;
          state_r    <= IDLE;
          busy       <= 1'b0;
        end else begin
          case (state_r)
            IDLE, OPR: begin
              if (is_digit_s) begin
                num_r   <= num_next_s;
                state_r <= NUM;
              end else begin
                state_r <= ERR;
              end
              busy <= 1'b1;
            end
            NUM: begin
              if (is_digit_s) begin
                num_r <= num_next_s;
              end else if (is_op_s) begin
                if (in == 8'h2A) begin
                  term_r     <= t_s;
                  mul_pend_r <= 1'b1;
                end else begin
                  sum_r      <= total_s;
                  neg_pend_r <= (in == 8'h2D);
                  mul_pend_r <= 1'b0;
                end
                num_r   <= '0;
                state_r <= OPR;
              end else begin
                state_r <= ERR;
              end
              busy <= 1'b1;
            end
            ERR: begin
              state_r <= ERR;
              busy    <= 1'b1;
            end
            default: begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: stimulus queues expected {err,result} per '=',
// a negedge monitor pops and compares on every res_valid pulse.
module tb_expr_eval;

  localparam int W = 16;

  logic         clk;
  logic         clr;
  logic         in_valid;
  logic [7:0]   in;
  logic         res_valid;
  logic [W-1:0] result;
  logic         err;
  logic         busy;

  int n_vec;
  int n_bad;
  logic [W:0] exp_q[$];

  expr_eval #(.W(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in        (in),
    .res_valid (res_valid),
    .result    (result),
    .err       (err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Inputs change #1 after a rising edge; each call consumes one clock.
  task automatic send_char(input logic [7:0] c);
    in       = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in       = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i]);
    end
  endtask

  task automatic expect_res(input logic e, input logic [W-1:0] r);
    exp_q.push_back({e, r});
  endtask

  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected res_valid", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("err", {31'd0, err}, {31'd0, e[W]});
        check("result", {16'd0, result}, {16'd0, e[W-1:0]});
      end
    end
  end

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    in_valid = 1'b0;
    in       = 8'h00;
    clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset res_valid", {31'd0, res_valid}, 32'd0);
    check("reset result", {16'd0, result}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    clr = 1'b1;
    @(posedge clk);
    #1;

    // 1: simple sum, busy during expression
    send_str("1+1");
    check("busy mid expr", {31'd0, busy}, 32'd1);
    expect_res(1'b0, 16'd2);
    send_str("=");
    check("busy after eq", {31'd0, busy}, 32'd0);

    // 2: precedence and back-to-back negative result
    expect_res(1'b0, 16'd24);
    send_str("12+3*4=");
    expect_res(1'b0, 16'hFFFC);
    send_str("2*3-10=");

    // 3: double operator error then recovery
    expect_res(1'b1, 16'd0);
    send_str("1++2=");
    expect_res(1'b0, 16'd7);
    send_str("7=");
    repeat (3) @(posedge clk);
    #1;
    check("result held", {16'd0, result}, 32'd7);
    check("err held", {31'd0, err}, 32'd0);

    // 4: idle gaps and spaces, then wrap-around product
    expect_res(1'b0, 16'd15);
    send_str("3");
    repeat (3) @(posedge clk);
    #1;
    send_str(" *5=");
    expect_res(1'b0, 16'd24464);
    send_str("300*300=");

    // 5: malformed endings
    expect_res(1'b1, 16'd0);
    send_str("=");
    expect_res(1'b1, 16'd0);
    send_str("4*=");
    expect_res(1'b1, 16'd0);
    send_str("4#2=");
    expect_res(1'b1, 16'd0);
    send_str("-3=");

    // extra: leading zeros and mixed precedence with subtraction
    expect_res(1'b0, 16'd7);
    send_str("0007=");
    expect_res(1'b0, 16'd0);
    send_str("5-3*2+1=");

    // 6: asynchronous reset mid-expression
    send_str("9+");
    check("busy before clr", {31'd0, busy}, 32'd1);
    #2;
    clr = 1'b0;
    #1;
    check("busy in clr", {31'd0, busy}, 32'd0);
    check("result in clr", {16'd0, result}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    expect_res(1'b0, 16'd4);
    send_str("4=");

    // drain scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
